// File: rtl/ecp5_lfps_pkg.sv
// Purpose: shared LFPS types, default timing constants and the burst classifier.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: lfps_class_e (burst class), tx_state_e (TX FSM encoding),
//           LFPS_* default timing in 250 MHz clocks, lfps_classify().
package ecp5_lfps_pkg;

  typedef enum logic [1:0] {
    LFPS_NONE = 2'd0,
    LFPS_PING = 2'd1,
    LFPS_POLL = 2'd2,
    LFPS_LONG = 2'd3
  } lfps_class_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_BURST = 2'd1,
    TX_GAP   = 2'd2
  } tx_state_e;

  localparam int LFPS_HALF_PERIOD   = 4;    // 16 ns -> 32 ns tPeriod
  localparam int LFPS_RX_PERIOD_MAX = 25;   // 100 ns without an edge ends a burst
  localparam int LFPS_PING_MAX      = 50;   // 200 ns
  localparam int LFPS_POLL_MIN      = 150;  // 600 ns
  localparam int LFPS_POLL_MAX      = 350;  // 1.4 us

  // Lengths between PING_MAX and POLL_MIN fall in no class and report NONE.
  function automatic lfps_class_e lfps_classify(input logic [15:0] len,
                                                input int ping_max,
                                                input int poll_min,
                                                input int poll_max);
    int l;
    l = int'(len);
    if (l <= ping_max)                     return LFPS_PING;
    else if (l >= poll_min && l <= poll_max) return LFPS_POLL;
    else if (l > poll_max)                 return LFPS_LONG;
    else                                   return LFPS_NONE;
  endfunction

endpackage

// File: rtl/ecp5_lfps_rx_ch.sv
// Purpose: one-channel LFPS receive detector with optional burst length/class measurement.
// Latency: 3-flop sync + 1 clock to rx_det; rx_burst_done 1 clock after the idle timeout.
// Backpressure: none; rx_burst_done is a single-cycle pulse, len/class hold until next burst.
// Ports: clk_250mhz, phy_reset (async, active-high), rxd_ldr (async input),
//        rx_det, rx_burst_done, rx_burst_len[15:0], rx_class[1:0].
// Build option: ECP5_LFPS_RX_CLASSIFY_EN enables length measurement and classification;
//               without it rx_burst_len/rx_class are tied to 0.
module ecp5_lfps_rx_ch
  import ecp5_lfps_pkg::*;
#(
  parameter int RX_PERIOD_MAX = LFPS_RX_PERIOD_MAX,
  parameter int PING_MAX      = LFPS_PING_MAX,
  parameter int POLL_MIN      = LFPS_POLL_MIN,
  parameter int POLL_MAX      = LFPS_POLL_MAX
) (
  input  logic        clk_250mhz,
  input  logic        phy_reset,
  input  logic        rxd_ldr,
  output logic        rx_det,
  output logic        rx_burst_done,
  output logic [15:0] rx_burst_len,
  output logic [1:0]  rx_class
);

  // Overlapping thresholds would make the class of a burst ambiguous.
  if (PING_MAX >= POLL_MIN || POLL_MIN > POLL_MAX) begin : g_bad_thresholds
    $error("ecp5_lfps_rx_ch: Ping/Polling thresholds overlap");
  end

  // sync[0] is the metastability catcher; edges are judged on sync[1]/sync[2].
  logic [2:0]  sync;
  logic [15:0] per_cnt;
  logic        edge_det;
  logic        timeout;
  logic        burst_end;

  assign edge_det  = sync[1] & ~sync[2];
  assign timeout   = per_cnt > 16'(RX_PERIOD_MAX);
  // An edge in the timeout cycle keeps the burst alive.
  assign burst_end = rx_det & timeout & ~edge_det;

  always_ff @(posedge clk_250mhz or posedge phy_reset) begin
    if (phy_reset) begin
      sync          <= 3'b000;
      per_cnt       <= 16'd0;
      rx_det        <= 1'b0;
      rx_burst_done <= 1'b0;
    end else begin
      sync          <= {sync[1:0], rxd_ldr};
      per_cnt       <= (edge_det || timeout) ? 16'd0 : per_cnt + 16'd1;
      if (edge_det)
        rx_det <= 1'b1;
      else if (timeout)
        rx_det <= 1'b0;
      rx_burst_done <= burst_end;
    end
  end

`ifdef ECP5_LFPS_RX_CLASSIFY_EN
  // len_cnt holds clocks elapsed since the first edge of the burst (0 at that edge),
  // last_edge snapshots it at each edge, so the reported length is first-to-last edge.
  logic [15:0] len_cnt;
  logic [15:0] last_edge;
  logic [15:0] len_q;
  lfps_class_e cls_q;

  always_ff @(posedge clk_250mhz or posedge phy_reset) begin
    if (phy_reset) begin
      len_cnt   <= 16'd0;
      last_edge <= 16'd0;
      len_q     <= 16'd0;
      cls_q     <= LFPS_NONE;
    end else begin
      if (edge_det && !rx_det)
        len_cnt <= 16'd1;
      else if (rx_det)
        len_cnt <= (len_cnt == 16'hFFFF) ? 16'hFFFF : len_cnt + 16'd1;
      else
        len_cnt <= 16'd0;

      if (edge_det)
        last_edge <= rx_det ? len_cnt : 16'd0;

      if (burst_end) begin
        len_q <= last_edge;
        cls_q <= lfps_classify(last_edge, PING_MAX, POLL_MIN, POLL_MAX);
      end
    end
  end

  assign rx_burst_len = len_q;
  assign rx_class     = cls_q;
`else
  assign rx_burst_len = 16'd0;
  assign rx_class     = 2'd0;
`endif

endmodule

// File: rtl/ecp5_lfps.sv
// Purpose: ECP5 LFPS burst generator and detector, NUM_CH independent channels.
// Latency: TX burst starts 1 clock after tx_req; RX see ecp5_lfps_rx_ch.
// Backpressure: none; a started burst and its gap always run to completion.
// Ports: clk_250mhz, phy_reset (async, active-high); tx_req/tx_busy/txd_ldr/txd_ldr_en
//        per channel, shared tx_burst_len/tx_repeat/tx_count; rxd_ldr/rx_det/
//        rx_burst_done per channel, rx_burst_len (16b/ch), rx_class (2b/ch).
// Build option: ECP5_LFPS_RX_CLASSIFY_EN (burst length and class reporting).
module ecp5_lfps
  import ecp5_lfps_pkg::*;
#(
  parameter int NUM_CH        = 1,
  parameter int HALF_PERIOD   = LFPS_HALF_PERIOD,
  parameter int RX_PERIOD_MAX = LFPS_RX_PERIOD_MAX,
  parameter int PING_MAX      = LFPS_PING_MAX,
  parameter int POLL_MIN      = LFPS_POLL_MIN,
  parameter int POLL_MAX      = LFPS_POLL_MAX
) (
  input  logic                 clk_250mhz,
  input  logic                 phy_reset,
  input  logic [NUM_CH-1:0]    tx_req,
  input  logic [15:0]          tx_burst_len,
  input  logic [15:0]          tx_repeat,
  input  logic [7:0]           tx_count,
  output logic [NUM_CH-1:0]    tx_busy,
  output logic [NUM_CH-1:0]    txd_ldr,
  output logic [NUM_CH-1:0]    txd_ldr_en,
  input  logic [NUM_CH-1:0]    rxd_ldr,
  output logic [NUM_CH-1:0]    rx_det,
  output logic [NUM_CH-1:0]    rx_burst_done,
  output logic [16*NUM_CH-1:0] rx_burst_len,
  output logic [2*NUM_CH-1:0]  rx_class
);

  localparam logic [1:0] ST_IDLE  = TX_IDLE;
  localparam logic [1:0] ST_BURST = TX_BURST;
  localparam logic [1:0] ST_GAP   = TX_GAP;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [1:0]  state;
    logic [15:0] len_q;   // burst length, latched at train start
    logic [15:0] gap_q;   // gap length, at least 1
    logic [7:0]  cnt_q;   // bursts per train, 0 = continuous
    logic [7:0]  sent;    // bursts completed in this train
    logic [15:0] tcnt;    // cycles spent in current BURST/GAP
    logic [15:0] hcnt;    // cycles spent in current txd_ldr half-period
    logic        ldr;
    logic        burst_last;
    logic        gap_last;

    assign burst_last = (tcnt == len_q - 16'd1);
    assign gap_last   = (tcnt == gap_q - 16'd1);

    always_ff @(posedge clk_250mhz or posedge phy_reset) begin
      if (phy_reset) begin
        state <= ST_IDLE;
        len_q <= 16'd0;
        gap_q <= 16'd0;
        cnt_q <= 8'd0;
        sent  <= 8'd0;
        tcnt  <= 16'd0;
        hcnt  <= 16'd0;
        ldr   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (tx_req[g] && tx_burst_len != 16'd0) begin
              state <= ST_BURST;
              len_q <= tx_burst_len;
              gap_q <= (tx_repeat > tx_burst_len) ? tx_repeat - tx_burst_len : 16'd1;
              cnt_q <= tx_count;
              sent  <= 8'd0;
              tcnt  <= 16'd0;
              hcnt  <= 16'd0;
              ldr   <= 1'b0;
            end
          end
          ST_BURST: begin
            if (hcnt == 16'(HALF_PERIOD - 1)) begin
              hcnt <= 16'd0;
              ldr  <= ~ldr;
            end else begin
              hcnt <= hcnt + 16'd1;
            end
            if (burst_last) begin
              state <= ST_GAP;
              tcnt  <= 16'd0;
              sent  <= sent + 8'd1;
            end else begin
              tcnt <= tcnt + 16'd1;
            end
          end
          ST_GAP: begin
            if (gap_last) begin
              tcnt <= 16'd0;
              // A dropped tx_req ends the train here, as does reaching the count.
              if (tx_req[g] && (cnt_q == 8'd0 || sent != cnt_q)) begin
                state <= ST_BURST;
                hcnt  <= 16'd0;
                ldr   <= 1'b0;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              tcnt <= tcnt + 16'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end

    assign tx_busy[g]    = (state != ST_IDLE);
    assign txd_ldr_en[g] = (state == ST_BURST);
    assign txd_ldr[g]    = ldr & (state == ST_BURST);

    ecp5_lfps_rx_ch #(
      .RX_PERIOD_MAX (RX_PERIOD_MAX),
      .PING_MAX      (PING_MAX),
      .POLL_MIN      (POLL_MIN),
      .POLL_MAX      (POLL_MAX)
    ) u_rx (
      .clk_250mhz    (clk_250mhz),
      .phy_reset     (phy_reset),
      .rxd_ldr       (rxd_ldr[g]),
      .rx_det        (rx_det[g]),
      .rx_burst_done (rx_burst_done[g]),
      .rx_burst_len  (rx_burst_len[16*g +: 16]),
      .rx_class      (rx_class[2*g +: 2])
    );
  end

endmodule

// File: tb/tb_ecp5_lfps.sv
module tb_ecp5_lfps;

  localparam int NCH  = 2;
  localparam int HALF = 4;
`ifdef ECP5_LFPS_RX_CLASSIFY_EN
  localparam bit CLS = 1'b1;
`else
  localparam bit CLS = 1'b0;
`endif

  logic                clk_250mhz = 1'b0;
  logic                phy_reset;
  logic [NCH-1:0]      tx_req;
  logic [15:0]         tx_burst_len;
  logic [15:0]         tx_repeat;
  logic [7:0]          tx_count;
  logic [NCH-1:0]      tx_busy;
  logic [NCH-1:0]      txd_ldr;
  logic [NCH-1:0]      txd_ldr_en;
  logic [NCH-1:0]      rxd_ldr;
  logic [NCH-1:0]      rx_det;
  logic [NCH-1:0]      rx_burst_done;
  logic [16*NCH-1:0]   rx_burst_len;
  logic [2*NCH-1:0]    rx_class;

  int checks = 0;
  int errors = 0;
  int ch0_act = 0;
  logic en_h [20000];
  logic ldr_h [20000];
  logic busy_h [20000];

  always #2 clk_250mhz = ~clk_250mhz;

  ecp5_lfps #(.NUM_CH(NCH)) dut (
    .clk_250mhz    (clk_250mhz),
    .phy_reset     (phy_reset),
    .tx_req        (tx_req),
    .tx_burst_len  (tx_burst_len),
    .tx_repeat     (tx_repeat),
    .tx_count      (tx_count),
    .tx_busy       (tx_busy),
    .txd_ldr       (txd_ldr),
    .txd_ldr_en    (txd_ldr_en),
    .rxd_ldr       (rxd_ldr),
    .rx_det        (rx_det),
    .rx_burst_done (rx_burst_done),
    .rx_burst_len  (rx_burst_len),
    .rx_class      (rx_class)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic all_out_zero();
    return ({tx_busy, txd_ldr, txd_ldr_en, rx_det, rx_burst_done, rx_burst_len, rx_class} == '0);
  endfunction

  // Advance one clock and sample 1 time unit after the edge; track any channel-0 activity.
  task automatic tick();
    @(posedge clk_250mhz);
    #1;
    if (tx_busy[0] || txd_ldr_en[0] || txd_ldr[0] || rx_det[0] || rx_burst_done[0] ||
        rx_burst_len[15:0] != 16'd0 || rx_class[1:0] != 2'd0)
      ch0_act++;
  endtask

  task automatic start_tx(input int ch, input int len, input int rep, input int cnt);
    tx_burst_len = 16'(len);
    tx_repeat    = 16'(rep);
    tx_count     = 8'(cnt);
    tx_req[ch]   = 1'b1;
    tick();
  endtask

  // Record n cycles of TX outputs (c = 0 is the first BURST cycle), dropping tx_req at drop_at.
  task automatic run_tx(input int ch, input int n, input int drop_at);
    for (int c = 0; c < n; c++) begin
      en_h[c]   = txd_ldr_en[ch];
      ldr_h[c]  = txd_ldr[ch];
      busy_h[c] = tx_busy[ch];
      if (c == drop_at) tx_req[ch] = 1'b0;
      tick();
    end
  endtask

  // Expected: nb bursts of len cycles every per cycles, txd_ldr period 2*HALF starting low.
  task automatic check_tx(input string tag, input int n, input int len, input int per, input int nb);
    int be = 0;
    int bl = 0;
    int bb = 0;
    int ne = 0;
    for (int c = 0; c < n; c++) begin
      bit b, e, l;
      b = (c < nb * per);
      e = b && ((c % per) < len);
      l = e && ((((c % per) / HALF) % 2) == 1);
      if (en_h[c] !== e) be++;
      if (ldr_h[c] !== l) bl++;
      if (busy_h[c] !== b) bb++;
      if (en_h[c] === 1'b1) ne++;
    end
    chk({tag, " en mismatches"}, be, 0);
    chk({tag, " ldr mismatches"}, bl, 0);
    chk({tag, " busy mismatches"}, bb, 0);
    chk({tag, " en cycles"}, ne, nb * len);
  endtask

  // Square wave (8-clock period, starting high) for n cycles, then wait for the burst to end.
  task automatic rx_burst(input string tag, input int ch, input int n, input int exp_len, input int exp_cls);
    int early = 0;
    int det_mid = 0;
    int seen = 0;
    int got_len = 0;
    int got_cls = 0;
    int det_at_done = 1;
    for (int c = 0; c < n; c++) begin
      rxd_ldr[ch] = ((c / 4) % 2 == 0);
      tick();
      if (rx_burst_done[ch]) early++;
      if (c == n / 2) det_mid = int'(rx_det[ch]);
    end
    rxd_ldr[ch] = 1'b0;
    for (int w = 0; w < 100 && seen == 0; w++) begin
      tick();
      if (rx_burst_done[ch]) begin
        seen        = 1;
        got_len     = int'(rx_burst_len[16*ch +: 16]);
        got_cls     = int'(rx_class[2*ch +: 2]);
        det_at_done = int'(rx_det[ch]);
      end
    end
    chk({tag, " rx_det during burst"}, det_mid, 1);
    chk({tag, " no done during burst"}, early, 0);
    chk({tag, " done seen"}, seen, 1);
    chk({tag, " rx_det low at done"}, det_at_done, 0);
    chk({tag, " rx_burst_len"}, got_len, CLS ? exp_len : 0);
    chk({tag, " rx_class"}, got_cls, CLS ? exp_cls : 0);
    tick();
    chk({tag, " done one cycle"}, int'(rx_burst_done[ch]), 0);
    chk({tag, " len held"}, int'(rx_burst_len[16*ch +: 16]), CLS ? exp_len : 0);
  endtask

  initial begin
    phy_reset    = 1'b1;
    tx_req       = '0;
    tx_burst_len = 16'd0;
    tx_repeat    = 16'd0;
    tx_count     = 8'd0;
    rxd_ldr      = '0;

    // Reset state
    repeat (3) tick();
    chk("outputs zero in reset", all_out_zero(), 1'b1);
    phy_reset = 1'b0;
    tick();
    chk("outputs zero after reset", all_out_zero(), 1'b1);

    // Three 250-cycle bursts 5000 apart, then IDLE by count (tx_req still high at that point)
    start_tx(0, 250, 5000, 3);
    run_tx(0, 15002, 15000);
    check_tx("tx count3", 15002, 250, 5000, 3);

    // Zero burst length never leaves IDLE
    tx_burst_len = 16'd0;
    tx_req[0]    = 1'b1;
    tick();
    tick();
    chk("len0 busy", int'(tx_busy[0]), 0);
    chk("len0 en", int'(txd_ldr_en[0]), 0);
    tx_req[0] = 1'b0;
    tick();

    // Continuous train, tx_req dropped mid second burst: burst + gap complete
    start_tx(0, 20, 50, 0);
    run_tx(0, 102, 60);
    check_tx("tx continuous drop", 102, 20, 50, 2);

    // tx_repeat below tx_burst_len: one-cycle gap
    start_tx(0, 10, 5, 2);
    run_tx(0, 24, 22);
    check_tx("tx min gap", 24, 10, 11, 2);

    // RX classes: 1 us Polling, 100 ns Ping, 400 ns invalid, 10 us Long
    rx_burst("rx 1us", 0, 250, 248, 2);
    rx_burst("rx 100ns", 0, 25, 24, 1);
    rx_burst("rx 400ns", 0, 100, 96, 0);
    rx_burst("rx 10us", 0, 2500, 2496, 3);

    // Reset mid TX burst and mid RX burst
    start_tx(0, 250, 300, 0);
    for (int c = 0; c < 100; c++) begin
      rxd_ldr[0] = ((c / 4) % 2 == 0);
      tick();
    end
    chk("pre-reset busy", int'(tx_busy[0]), 1);
    chk("pre-reset en", int'(txd_ldr_en[0]), 1);
    chk("pre-reset rx_det", int'(rx_det[0]), 1);
    phy_reset = 1'b1;
    #1;
    chk("reset en immediate", int'(txd_ldr_en[0]), 0);
    chk("reset outputs immediate", all_out_zero(), 1'b1);
    tx_req  = '0;
    rxd_ldr = '0;
    tick();
    tick();
    phy_reset = 1'b0;
    ch0_act   = 0;
    repeat (80) tick();
    chk("post-reset ch0 quiet", ch0_act, 0);

    // Channel 1 only: channel 0 must stay silent
    ch0_act = 0;
    start_tx(1, 16, 32, 2);
    run_tx(1, 66, 64);
    check_tx("ch1 tx", 66, 16, 32, 2);
    rx_burst("ch1 rx ping", 1, 25, 24, 1);
    chk("ch0 untouched by ch1", ch0_act, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
